// File: rtl/multicycle_control_if.sv
// Unified memory port shared by instruction fetch and data access,
// with a waitrequest handshake that stretches the current access.
interface multicycle_control_if;
  logic mem_waitrequest;
  logic mem_read;
  logic mem_write;
  logic i_or_d;

  modport master (
    input  mem_waitrequest,
    output mem_read,
    output mem_write,
    output i_or_d
  );

  modport slave (
    output mem_waitrequest,
    input  mem_read,
    input  mem_write,
    input  i_or_d
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT over one shared memory port.
// Optional stall counter output enabled by defining MULTICYCLE_CONTROL_STALL_CNT_EN.
module multicycle_control #(
  parameter bit HALT_ON_ILLEGAL = 1'b0,
  parameter int STALL_CNT_W     = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] instruction_opcode,
  input  logic [5:0] func_code,
  input  logic       halt_req,
  multicycle_control_if.master mem,
  output logic [2:0] state,
  output logic       active,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] reg_dst,
  output logic [1:0] alu_src_b,
  output logic [5:0] alu_op,
  output logic       illegal_instr
`ifdef MULTICYCLE_CONTROL_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    C_RTYPE, C_JR, C_J, C_JAL, C_BRANCH, C_IMM, C_LW, C_SW, C_ILLEGAL
  } instr_e;

  if (STALL_CNT_W < 1) begin : g_bad_width
    $error("STALL_CNT_W must be at least 1");
  end

  state_e state_q, state_d;
  instr_e cls;
  logic   mem_read_c, mem_write_c, i_or_d_c;

  // The IR is stable from DECODE onwards, so the class can be decoded live every cycle.
  always_comb begin
    cls = C_ILLEGAL;
    case (instruction_opcode)
      6'h00:                      cls = (func_code == 6'h08) ? C_JR : C_RTYPE;
      6'h02:                      cls = C_J;
      6'h03:                      cls = C_JAL;
      6'h04, 6'h05:               cls = C_BRANCH;
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F: cls = C_IMM;
      6'h23:                      cls = C_LW;
      6'h2B:                      cls = C_SW;
      default:                    cls = C_ILLEGAL;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_d       = state_q;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    reg_dst       = 2'd0;
    alu_src_b     = 2'd0;
    alu_op        = 6'h00;
    illegal_instr = 1'b0;
    mem_read_c    = 1'b0;
    mem_write_c   = 1'b0;
    i_or_d_c      = 1'b0;

    case (state_q)
      S_FETCH: begin
        alu_op    = 6'h09;
        alu_src_b = 2'd1;
        if (halt_req) begin
          state_d = S_HALT;
        end else begin
          mem_read_c = 1'b1;
          if (!mem.mem_waitrequest) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        alu_op    = 6'h09;
        alu_src_b = 2'd3;
        if (cls == C_ILLEGAL) begin
          illegal_instr = 1'b1;
          state_d       = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op  = instruction_opcode;
        state_d = S_FETCH;
        case (cls)
          C_RTYPE: begin
            alu_src_a = 1'b1;
            state_d   = S_WB;
          end
          C_JR, C_J: pc_write = 1'b1;
          C_JAL: begin
            pc_write  = 1'b1;
            reg_write = 1'b1;
            reg_dst   = 2'd2;
          end
          C_BRANCH: begin
            alu_src_a     = 1'b1;
            pc_write_cond = 1'b1;
          end
          C_IMM: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            state_d   = S_WB;
          end
          C_LW, C_SW: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            state_d   = S_MEM;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        i_or_d_c    = 1'b1;
        mem_read_c  = (cls == C_LW);
        mem_write_c = (cls == C_SW);
        if (!mem.mem_waitrequest) state_d = (cls == C_LW) ? S_WB : S_FETCH;
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls == C_LW);
        reg_dst    = (cls == C_RTYPE) ? 2'd1 : 2'd0;
        state_d    = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // Reset is synchronous, so the strobes must be quiet combinationally during the reset cycle.
    if (!reset_n) begin
      state_d       = S_FETCH;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      reg_dst       = 2'd0;
      alu_src_b     = 2'd0;
      illegal_instr = 1'b0;
      mem_read_c    = 1'b0;
      mem_write_c   = 1'b0;
      i_or_d_c      = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  assign state          = state_q;
  assign active         = reset_n && (state_q != S_HALT);
  assign mem.mem_read   = mem_read_c;
  assign mem.mem_write  = mem_write_c;
  assign mem.i_or_d     = i_or_d_c;

`ifdef MULTICYCLE_CONTROL_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == S_FETCH || state_q == S_MEM) && mem.mem_waitrequest && (stall_q != '1))
      stall_d = stall_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus a randomized
// instruction stream checked against a per-instruction phase model.
module tb_multicycle_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [5:0] opcode, func;
  logic       halt_req;

  multicycle_control_if mif ();
  multicycle_control_if mif_nop ();
  assign mif_nop.mem_waitrequest = mif.mem_waitrequest;

  logic [2:0] state, n_state;
  logic       active, ir_write, pc_write, pc_write_cond, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] reg_dst, alu_src_b;
  logic [5:0] alu_op;
  logic       illegal_instr;
  logic       n_active, n_ir_write, n_pc_write, n_pc_write_cond, n_mem_to_reg, n_reg_write, n_alu_src_a;
  logic [1:0] n_reg_dst, n_alu_src_b;
  logic [5:0] n_alu_op;
  logic       n_illegal_instr;
`ifdef MULTICYCLE_CONTROL_STALL_CNT_EN
  logic [15:0] stall_cycles, n_stall_cycles;
`endif

  multicycle_control #(.HALT_ON_ILLEGAL(1'b1), .STALL_CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .instruction_opcode(opcode), .func_code(func),
    .halt_req(halt_req), .mem(mif.master), .state(state), .active(active),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .reg_dst(reg_dst), .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal_instr(illegal_instr)
`ifdef MULTICYCLE_CONTROL_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  multicycle_control #(.HALT_ON_ILLEGAL(1'b0), .STALL_CNT_W(16)) dut_nop (
    .clk(clk), .reset_n(reset_n), .instruction_opcode(opcode), .func_code(func),
    .halt_req(halt_req), .mem(mif_nop.master), .state(n_state), .active(n_active),
    .ir_write(n_ir_write), .pc_write(n_pc_write), .pc_write_cond(n_pc_write_cond),
    .mem_to_reg(n_mem_to_reg), .reg_write(n_reg_write), .alu_src_a(n_alu_src_a),
    .reg_dst(n_reg_dst), .alu_src_b(n_alu_src_b), .alu_op(n_alu_op), .illegal_instr(n_illegal_instr)
`ifdef MULTICYCLE_CONTROL_STALL_CNT_EN
    , .stall_cycles(n_stall_cycles)
`endif
  );

  int errors = 0;
  int checks = 0;
  int exp_stall = 0;

  // One clock cycle: inputs change just after the rising edge, outputs are inspected at the falling edge.
  task automatic apply(input logic [5:0] op, input logic [5:0] fn, input logic w, input logic h);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    opcode = op;
    func = fn;
    mif.mem_waitrequest = w;
    halt_req = h;
    @(negedge clk);
  endtask

  task automatic apply_reset(input logic [5:0] op, input logic w);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    opcode = op;
    func = 6'h00;
    mif.mem_waitrequest = w;
    halt_req = 1'b0;
    @(negedge clk);
    exp_stall = 0;
  endtask

  function automatic logic [9:0] strobes();
    return {active, ir_write, pc_write, pc_write_cond, mem_to_reg, reg_write,
            alu_src_a, mif.mem_read, mif.mem_write, mif.i_or_d};
  endfunction

  task automatic test_reset();
    apply_reset(6'h3F, 1'b1);
    apply_reset(6'h23, 1'b0);
    checks++;
    if (strobes() !== 10'b0) begin
      errors++; $display("FAIL reset_strobes: got %b expected %b", strobes(), 10'b0);
    end
    checks++;
    if (illegal_instr !== 1'b0) begin
      errors++; $display("FAIL reset_illegal: got %b expected 0", illegal_instr);
    end
    apply(6'h00, 6'h21, 1'b1, 1'b0);
    checks++;
    if ({state, active, mif.mem_read, mif.i_or_d, alu_src_b, alu_op} !== {3'd0, 1'b1, 1'b1, 1'b0, 2'd1, 6'h09}) begin
      errors++; $display("FAIL reset_fetch: got st=%0d act=%b rd=%b iod=%b srcb=%0d op=%h expected st=0 act=1 rd=1 iod=0 srcb=1 op=09",
                         state, active, mif.mem_read, mif.i_or_d, alu_src_b, alu_op);
    end
  endtask

  task automatic test_rtype();
    int st_e[5] = '{0, 1, 2, 4, 0};
    int rw_e[5] = '{0, 0, 0, 1, 0};
    int rd_e[5] = '{0, 0, 0, 1, 0};
    apply_reset(6'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      apply(6'h00, 6'h21, 1'b0, 1'b0);
      checks++;
      if ({state, reg_write, reg_dst} !== {3'(st_e[i]), 1'(rw_e[i]), 2'(rd_e[i])}) begin
        errors++; $display("FAIL rtype_cycle%0d: got st=%0d rw=%b rd=%0d expected st=%0d rw=%0d rd=%0d",
                           i, state, reg_write, reg_dst, st_e[i], rw_e[i], rd_e[i]);
      end
    end
  endtask

  task automatic test_lw_wait();
    int   st_e[9] = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
    logic w_e[9]  = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    apply_reset(6'h23, 1'b0);
    for (int i = 0; i < 9; i++) begin
      apply(6'h23, 6'h00, w_e[i], 1'b0);
      checks++;
      if (state !== 3'(st_e[i])) begin
        errors++; $display("FAIL lw_state%0d: got %0d expected %0d", i, state, st_e[i]);
      end
      if (st_e[i] == 3) begin
        checks++;
        if ({mif.mem_read, mif.i_or_d, mif.mem_write} !== 3'b110) begin
          errors++; $display("FAIL lw_mem%0d: got rd/iod/wr=%b expected 110", i, {mif.mem_read, mif.i_or_d, mif.mem_write});
        end
      end
      if (st_e[i] == 4) begin
        checks++;
        if ({mem_to_reg, reg_write, reg_dst} !== {1'b1, 1'b1, 2'd0}) begin
          errors++; $display("FAIL lw_wb: got m2r=%b rw=%b rd=%0d expected m2r=1 rw=1 rd=0", mem_to_reg, reg_write, reg_dst);
        end
      end
    end
`ifdef MULTICYCLE_CONTROL_STALL_CNT_EN
    checks++;
    if (stall_cycles !== 16'd3) begin
      errors++; $display("FAIL lw_stall: got %0d expected 3", stall_cycles);
    end
`endif
  endtask

  task automatic test_jal();
    int st_e[4] = '{0, 1, 2, 0};
    apply_reset(6'h03, 1'b0);
    for (int i = 0; i < 4; i++) begin
      apply(6'h03, 6'h00, 1'b0, 1'b0);
      checks++;
      if (state !== 3'(st_e[i])) begin
        errors++; $display("FAIL jal_state%0d: got %0d expected %0d", i, state, st_e[i]);
      end
      if (i == 0) begin
        checks++;
        if (alu_op !== 6'h09) begin
          errors++; $display("FAIL jal_fetch_aluop: got %h expected 09", alu_op);
        end
      end
      if (i == 2) begin
        checks++;
        if ({pc_write, reg_write, reg_dst, alu_op} !== {1'b1, 1'b1, 2'd2, 6'h03}) begin
          errors++; $display("FAIL jal_exec: got pcw=%b rw=%b rd=%0d op=%h expected pcw=1 rw=1 rd=2 op=03",
                             pc_write, reg_write, reg_dst, alu_op);
        end
      end
    end
  endtask

  task automatic test_illegal();
    apply_reset(6'h3F, 1'b0);
    apply(6'h3F, 6'h00, 1'b0, 1'b0);
    apply(6'h3F, 6'h00, 1'b0, 1'b0);
    checks++;
    if ({state, illegal_instr, n_state, n_illegal_instr} !== {3'd1, 1'b1, 3'd1, 1'b1}) begin
      errors++; $display("FAIL illegal_decode: got st=%0d ill=%b nst=%0d nill=%b expected st=1 ill=1 nst=1 nill=1",
                         state, illegal_instr, n_state, n_illegal_instr);
    end
    apply(6'h3F, 6'h00, 1'b0, 1'b0);
    checks++;
    if ({state, active, illegal_instr, n_state, n_illegal_instr} !== {3'd5, 1'b0, 1'b0, 3'd0, 1'b0}) begin
      errors++; $display("FAIL illegal_after: got st=%0d act=%b ill=%b nst=%0d nill=%b expected st=5 act=0 ill=0 nst=0 nill=0",
                         state, active, illegal_instr, n_state, n_illegal_instr);
    end
    apply(6'h00, 6'h21, 1'b0, 1'b0);
    checks++;
    if ({state, strobes()} !== {3'd5, 10'b0}) begin
      errors++; $display("FAIL halt_absorb: got st=%0d strobes=%b expected st=5 strobes=0", state, strobes());
    end
  endtask

  task automatic test_halt();
    apply_reset(6'h00, 1'b0);
    apply(6'h00, 6'h21, 1'b0, 1'b1);
    checks++;
    if ({state, mif.mem_read, ir_write} !== {3'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL halt_req_fetch: got st=%0d rd=%b irw=%b expected st=0 rd=0 irw=0", state, mif.mem_read, ir_write);
    end
    apply(6'h00, 6'h21, 1'b0, 1'b0);
    checks++;
    if ({state, strobes()} !== {3'd5, 10'b0}) begin
      errors++; $display("FAIL halt_req_halted: got st=%0d strobes=%b expected st=5 strobes=0", state, strobes());
    end
    apply_reset(6'h00, 1'b0);
    apply(6'h00, 6'h21, 1'b1, 1'b0);
    checks++;
    if ({state, active} !== {3'd0, 1'b1}) begin
      errors++; $display("FAIL halt_exit: got st=%0d act=%b expected st=0 act=1", state, active);
    end
  endtask

  task automatic test_sw_reset();
    apply_reset(6'h2B, 1'b0);
    apply(6'h2B, 6'h00, 1'b0, 1'b0);
    apply(6'h2B, 6'h00, 1'b0, 1'b0);
    apply(6'h2B, 6'h00, 1'b0, 1'b0);
    checks++;
    if ({state, alu_src_a, alu_src_b} !== {3'd2, 1'b1, 2'd2}) begin
      errors++; $display("FAIL sw_exec: got st=%0d srca=%b srcb=%0d expected st=2 srca=1 srcb=2", state, alu_src_a, alu_src_b);
    end
    apply(6'h2B, 6'h00, 1'b1, 1'b0);
    checks++;
    if ({state, mif.mem_write, mif.mem_read, mif.i_or_d} !== {3'd3, 1'b1, 1'b0, 1'b1}) begin
      errors++; $display("FAIL sw_mem: got st=%0d wr=%b rd=%b iod=%b expected st=3 wr=1 rd=0 iod=1",
                         state, mif.mem_write, mif.mem_read, mif.i_or_d);
    end
    apply_reset(6'h2B, 1'b1);
    checks++;
    if (mif.mem_write !== 1'b0) begin
      errors++; $display("FAIL sw_reset_wr: got %b expected 0", mif.mem_write);
    end
    apply(6'h2B, 6'h00, 1'b1, 1'b0);
    checks++;
    if ({state, mif.mem_write} !== {3'd0, 1'b0}) begin
      errors++; $display("FAIL sw_after_reset: got st=%0d wr=%b expected st=0 wr=0", state, mif.mem_write);
    end
`ifdef MULTICYCLE_CONTROL_STALL_CNT_EN
    checks++;
    if (stall_cycles !== 16'd0) begin
      errors++; $display("FAIL sw_stall_clear: got %0d expected 0", stall_cycles);
    end
`endif
  endtask

  // Class codes: 0 R-type, 1 JR, 2 J, 3 JAL, 4 branch, 5 immediate, 6 LW, 7 SW.
  task automatic test_random();
    apply_reset(6'h00, 1'b0);
    for (int n = 0; n < 60; n++) begin
      int         cls;
      int         fw;
      int         mw;
      logic [5:0] op;
      logic [5:0] fn;
      int         ph[$];
      logic       wq[$];
      cls = $urandom_range(0, 7);
      fw  = $urandom_range(0, 2);
      mw  = $urandom_range(0, 2);
      fn  = 6'($urandom_range(0, 63));
      case (cls)
        0: begin op = 6'h00; if (fn == 6'h08) fn = 6'h20; end
        1: begin op = 6'h00; fn = 6'h08; end
        2: op = 6'h02;
        3: op = 6'h03;
        4: op = 6'($urandom_range(4, 5));
        5: op = 6'($urandom_range(8, 15));
        6: op = 6'h23;
        default: op = 6'h2B;
      endcase
      for (int i = 0; i < fw; i++) begin ph.push_back(0); wq.push_back(1'b1); end
      ph.push_back(0); wq.push_back(1'b0);
      ph.push_back(1); wq.push_back(1'($urandom_range(0, 1)));
      ph.push_back(2); wq.push_back(1'($urandom_range(0, 1)));
      if (cls == 6 || cls == 7) begin
        for (int i = 0; i < mw; i++) begin ph.push_back(3); wq.push_back(1'b1); end
        ph.push_back(3); wq.push_back(1'b0);
      end
      if (cls == 0 || cls == 5 || cls == 6) begin ph.push_back(4); wq.push_back(1'($urandom_range(0, 1))); end
      for (int i = 0; i < ph.size(); i++) begin
        logic [7:0] exp_v, got_v;
        int p;
        logic w;
        p = ph[i];
        w = wq[i];
        apply(op, fn, w, 1'b0);
        exp_v = {3'(p),
                 (p == 0) || (p == 3 && cls == 6),
                 (p == 3 && cls == 7),
                 (p == 4) || (p == 2 && cls == 3),
                 (p == 0 && !w),
                 (p == 0 && !w) || (p == 2 && (cls inside {1, 2, 3}))};
        got_v = {state, mif.mem_read, mif.mem_write, reg_write, ir_write, pc_write};
        if ((p == 0 || p == 3) && w) exp_stall++;
        checks++;
        if (got_v !== exp_v) begin
          errors++; $display("FAIL rand_instr%0d_cycle%0d op=%h: got st/rd/wr/rw/irw/pcw=%b expected %b",
                             n, i, op, got_v, exp_v);
        end
      end
    end
    apply(6'h00, 6'h21, 1'b0, 1'b0);
    checks++;
    if (state !== 3'd0) begin
      errors++; $display("FAIL rand_end_state: got %0d expected 0", state);
    end
`ifdef MULTICYCLE_CONTROL_STALL_CNT_EN
    checks++;
    if (stall_cycles !== 16'(exp_stall)) begin
      errors++; $display("FAIL rand_stall: got %0d expected %0d", stall_cycles, exp_stall);
    end
`endif
  endtask

  initial begin
    reset_n = 1'b0;
    opcode = 6'h00;
    func = 6'h00;
    halt_req = 1'b0;
    mif.mem_waitrequest = 1'b0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_jal();
    test_illegal();
    test_halt();
    test_sw_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
